// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM controller definitions: arbiter state encoding, refresh defaults,
// SDRAM command encodings and core timing constants.
package sdram_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StAccess  = 2'd1,
      StRefresh = 2'd2
   } arb_state_e;

   localparam int unsigned DefRefreshInterval = 390;
   localparam int unsigned DefMaxPostpone     = 3;

   // {cs_n, ras_n, cas_n, we_n}
   typedef enum logic [3:0] {
      CmdLoadMode  = 4'b0000,
      CmdRefresh   = 4'b0001,
      CmdPrecharge = 4'b0010,
      CmdActive    = 4'b0011,
      CmdWrite     = 4'b0100,
      CmdRead      = 4'b0101,
      CmdNop       = 4'b0111
   } sdram_cmd_e;

   localparam int unsigned TRcd = 2;
   localparam int unsigned TRp  = 2;
   localparam int unsigned TRfc = 7;
   localparam int unsigned TCas = 2;

endpackage

// File: rtl/sdram_arbiter_refresh_timer.sv
// Refresh interval timer plus saturating count of owed (postponed) refreshes.
module sdram_refresh_timer
   import sdram_arbiter_pkg::*;
#(
   parameter int unsigned REFRESH_INTERVAL = DefRefreshInterval,
   parameter int unsigned MAX_POSTPONE     = DefMaxPostpone
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       enable,
   input  logic       decrement,
   output logic [1:0] refresh_owed
);

   localparam int unsigned TimerWidth =
      (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(REFRESH_INTERVAL - 1);
   localparam logic [1:0]            OwedMax   = 2'(MAX_POSTPONE);

   logic [TimerWidth-1:0] timer_q, timer_d;
   logic [1:0]            owed_q, owed_d;
   logic                  tick;

   always_comb begin
      tick    = enable && (timer_q == TimerLast);
      timer_d = '0;
      owed_d  = '0;
      if (enable) begin
         timer_d = tick ? '0 : timer_q + 1'b1;
         owed_d  = owed_q;
         // A tick landing on the same edge as a completed refresh nets to zero.
         if (tick && !decrement) begin
            if (owed_q != OwedMax) owed_d = owed_q + 2'd1;
         end else if (decrement && !tick && (owed_q != 2'd0)) begin
            owed_d = owed_q - 2'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         timer_q <= '0;
         owed_q  <= '0;
      end else begin
         timer_q <= timer_d;
         owed_q  <= owed_d;
      end
   end

   assign refresh_owed = owed_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port (CPU/DMA) SDRAM sequencer arbiter with round-robin tie break and
// postponable refresh scheduling.
module sdram_arbiter
   import sdram_arbiter_pkg::*;
#(
   parameter int unsigned REFRESH_INTERVAL = DefRefreshInterval,
   parameter int unsigned MAX_POSTPONE     = DefMaxPostpone
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       INIT_DONE,
   input  logic       REQ0,
   input  logic       REQ1,
   output logic       GNT0,
   output logic       GNT1,
   output logic       SEQ_START,
   output logic       SEQ_REFRESH,
   output logic       SEQ_PORT,
   input  logic       SEQ_DONE,
   output logic [1:0] REFRESH_OWED
);

   localparam logic [1:0] OwedMax = 2'(MAX_POSTPONE);

   arb_state_e state_q, state_d;
   logic       last_q, last_d;
   logic       port_q, port_d;
   logic       start_q, start_d;
   logic       pick;
   logic       refresh_dec;

   sdram_refresh_timer #(
      .REFRESH_INTERVAL (REFRESH_INTERVAL),
      .MAX_POSTPONE     (MAX_POSTPONE)
   ) u_refresh_timer (
      .CLK          (CLK),
      .RESET        (RESET),
      .enable       (INIT_DONE),
      .decrement    (refresh_dec),
      .refresh_owed (REFRESH_OWED)
   );

   assign refresh_dec = INIT_DONE && (state_q == StRefresh) && SEQ_DONE;
   // With both ports requesting, serve the one not served last.
   assign pick        = (REQ0 && REQ1) ? ~last_q : REQ1;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      port_d  = port_q;
      start_d = 1'b0;
      if (!INIT_DONE) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (REFRESH_OWED == OwedMax) begin
                  state_d = StRefresh;
                  start_d = 1'b1;
               end else if (REQ0 || REQ1) begin
                  state_d = StAccess;
                  start_d = 1'b1;
                  port_d  = pick;
                  last_d  = pick;
               end else if (REFRESH_OWED != 2'd0) begin
                  state_d = StRefresh;
                  start_d = 1'b1;
               end
            end
            StAccess, StRefresh: begin
               if (SEQ_DONE) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         port_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         port_q  <= port_d;
         start_q <= start_d;
      end
   end

   assign GNT0        = (state_q == StAccess) && !port_q;
   assign GNT1        = (state_q == StAccess) && port_q;
   assign SEQ_START   = start_q;
   assign SEQ_REFRESH = (state_q == StRefresh);
   assign SEQ_PORT    = port_q;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_INTERVAL, default 390, CLK cycles between refresh ticks.
REQ-002 SHALL have parameter MAX_POSTPONE, default 3, maximum owed refreshes (1..3).
REQ-003 SHALL have port CLK, input, 1, SDRAM clock; all state changes on rising edge.
REQ-004 SHALL have port RESET, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port INIT_DONE, input, 1, high once SDRAM power-up init sequence is complete.
REQ-006 SHALL have port REQ0, input, 1, CPU port access request, level.
REQ-007 SHALL have port REQ1, input, 1, DMA port access request, level.
REQ-008 SHALL have port GNT0, output, 1, CPU port owns sequencer.
REQ-009 SHALL have port GNT1, output, 1, DMA port owns sequencer.
REQ-010 SHALL have port SEQ_START, output, 1, one-cycle pulse starting a sequencer cycle.
REQ-011 SHALL have port SEQ_REFRESH, output, 1, current cycle is refresh (valid while SEQ_START or busy).
REQ-012 SHALL have port SEQ_PORT, output, 1, port index of current access cycle.
REQ-013 SHALL have port SEQ_DONE, input, 1, one-cycle pulse from sequencer, cycle complete.
REQ-014 SHALL have port REFRESH_OWED, output, 2, count of postponed refreshes.

Function
REQ-015 SHALL implement states IDLE, ACCESS, REFRESH; only IDLE starts new cycles.
REQ-016 Refresh timer SHALL count 0..REFRESH_INTERVAL-1, wrap to 0, and emit a tick on the wrap cycle; width = ceil(log2(REFRESH_INTERVAL)).
REQ-017 Tick SHALL increment REFRESH_OWED, saturating at MAX_POSTPONE.
REQ-018 While INIT_DONE low: timer held at 0, REFRESH_OWED 0, state IDLE, no grants, no SEQ_START.
REQ-019 IDLE priority: REFRESH_OWED == MAX_POSTPONE -> REFRESH; else any REQ -> ACCESS; else REFRESH_OWED > 0 -> REFRESH; else stay IDLE.
REQ-020 Entry to ACCESS or REFRESH SHALL assert SEQ_START for exactly the first cycle in that state: REQ sampled high in IDLE at edge N -> SEQ_START and GNTx high after edge N.
REQ-021 Port choice: single requester wins; both requesting -> port not equal to last-served pointer LAST; LAST updates to granted port on entry to ACCESS; LAST resets to 1 (CPU wins first tie).
REQ-022 GNTx and SEQ_PORT SHALL hold stable from entry to ACCESS until the edge sampling SEQ_DONE, then GNTx deasserts and state returns to IDLE.
REQ-023 REQ deasserted mid-ACCESS SHALL be ignored; the cycle completes and grant holds until SEQ_DONE.
REQ-024 SEQ_DONE in REFRESH SHALL decrement REFRESH_OWED; coincident tick SHALL leave it unchanged (net zero).
REQ-025 SEQ_DONE sampled in IDLE SHALL be ignored.
REQ-026 Back-to-back: after SEQ_DONE, at least one IDLE cycle SHALL occur before next SEQ_START.
REQ-027 GNT0 and GNT1 SHALL never be high simultaneously; SEQ_REFRESH high implies both grants low.

Reset
REQ-028 RESET low SHALL asynchronously force: state IDLE, GNT0 0, GNT1 0, SEQ_START 0, SEQ_REFRESH 0, SEQ_PORT 0, REFRESH_OWED 0, timer 0, LAST 1.
REQ-029 Reset mid-cycle SHALL abandon the cycle; no SEQ_START until INIT_DONE and a fresh IDLE decision.

Structure
REQ-030 State encodings and default refresh constants SHALL live in shared sdram_defines.v alongside SDRAM command and timing constants.
REQ-031 Timer plus owed counter SHALL be one sub-module, sdram_refresh_timer, with inputs tick-enable and decrement, outputs REFRESH_OWED.
REQ-032 Arbiter FSM and round-robin pointer SHALL remain in sdram_arbiter; total RTL 120-400 lines.

Verification (bench: REFRESH_INTERVAL=8, MAX_POSTPONE=3, sequencer model returns SEQ_DONE 4 cycles after SEQ_START)
REQ-033 INIT_DONE low 50 cycles, REQ0 high -> no grant, REFRESH_OWED 0; INIT_DONE high -> GNT0 and SEQ_START one edge later.
REQ-034 REQ0 and REQ1 held high continuously, no refresh owed -> grants alternate GNT0, GNT1, GNT0..., each for 5 cycles, one IDLE cycle between.
REQ-035 REQ0 held high 40 cycles -> REFRESH_OWED reaches 3 after 3 ticks, next IDLE forces REFRESH before further GNT0.
REQ-036 Tick coincident with refresh SEQ_DONE, REFRESH_OWED=2 -> stays 2.
REQ-037 RESET low during ACCESS with GNT1 high -> all outputs 0 immediately; after release, first tie grants CPU.
REQ-038 REQ1 pulsed 1 cycle then dropped -> GNT1 held until SEQ_DONE, then IDLE; no second SEQ_START.
